imem_wb_responder: RTL and testbench

//  Wishbone-classic instruction-memory responder (slave) for the fetch port.

---
 rtl/imem_wb_responder_if.sv | 29 ++
 rtl/imem_wb_responder.sv | 167 ++++++++++++++++
 tb/tb_imem_wb_responder.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_wb_responder_if.sv
// rtl/imem_wb_responder_if.sv - Wishbone-classic instruction fetch bus between core and imem responder
// Signals:
//   iaddr_i  32  byte address           idat_i  32  write data
//   isel_i    4  byte-lane select       icyc_i   1  bus cycle active
//   istb_i    1  strobe                 iwe_i    1  write enable
//   idat_o   32  instruction word       iack_o   1  normal termination pulse
//   ierr_o    1  error termination pulse
// Modports: master (core side), slave (memory side).
interface imem_wb_responder_if;
    logic [31:0] iaddr_i;
    logic [31:0] idat_i;
    logic [3:0]  isel_i;
    logic        icyc_i;
    logic        istb_i;
    logic        iwe_i;
    logic [31:0] idat_o;
    logic        iack_o;
    logic        ierr_o;

    modport master (
        output iaddr_i, idat_i, isel_i, icyc_i, istb_i, iwe_i,
        input  idat_o, iack_o, ierr_o
    );

    modport slave (
        input  iaddr_i, idat_i, isel_i, icyc_i, istb_i, iwe_i,
        output idat_o, iack_o, ierr_o
    );
endinterface

// File: rtl/imem_wb_responder.sv
// rtl/imem_wb_responder.sv - Wishbone-classic instruction-memory responder with programmable wait states
// Purpose: answers fetch cycles from an internal word array after LATENCY wait states;
//   misaligned, out-of-range and (in ROM builds) write requests get a one-cycle ierr_o.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous reset, active-low
//   bus  imem_wb_responder_if.slave (iaddr_i/idat_i/isel_i/icyc_i/istb_i/iwe_i in,
//        idat_o/iack_o/ierr_o out)
// Optional feature: define IMEM_WRITE_EN to accept byte-masked writes; left undefined
//   the array is read-only and any write request is terminated with ierr_o.
module imem_wb_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned LATENCY    = 1,
    parameter string       MEM_FILE   = "imem.hex"
) (
    input  logic               clk,
    input  logic               rst,
    imem_wb_responder_if.slave bus
);
    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [3:0]  LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
`ifdef IMEM_WRITE_EN
    localparam bit WRITE_EN = 1'b1;
`else
    localparam bit WRITE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                state, state_n;
    logic [3:0]            cnt, cnt_n;
    logic [31:0]           mem [DEPTH];

    logic [31:0]           req_off;
    logic                  req_bad;
    logic                  accept;
    logic                  enter_resp;
    logic                  resp_err;

    logic [ADDR_WIDTH-1:0] a_idx;
    logic                  a_we;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic                  cur_we;

    logic [31:0]           idat_q;
    logic                  iack_q;
    logic                  ierr_q;

    // Request decode on the live bus; only meaningful in IDLE where it is accepted.
    assign req_off = bus.iaddr_i - BASE_ADDR;

    always_comb begin
        req_bad = (bus.iaddr_i[1:0] != 2'b00)
               || (bus.iaddr_i < BASE_ADDR)
               || (req_off[31:ADDR_WIDTH+2] != '0)
               || (bus.iwe_i && !WRITE_EN);
    end

    // With LATENCY=0 the response is produced straight from IDLE, so the
    // data path must see the live request rather than the latched copy.
    assign cur_idx = (state == S_IDLE) ? req_off[ADDR_WIDTH+1:2] : a_idx;
    assign cur_we  = (state == S_IDLE) ? bus.iwe_i : a_we;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        accept     = 1'b0;
        enter_resp = 1'b0;
        resp_err   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.icyc_i && bus.istb_i) begin
                    accept = 1'b1;
                    if (req_bad) begin
                        state_n    = S_RESP;
                        enter_resp = 1'b1;
                        resp_err   = 1'b1;
                    end else if (LATENCY == 0) begin
                        state_n    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_n = S_WAIT;
                        cnt_n   = LAT_M1;
                    end
                end
            end
            S_WAIT: begin
                // Abort wins over a response that would otherwise start this edge.
                if (!bus.icyc_i) begin
                    state_n = S_IDLE;
                end else if (cnt == 4'd0) begin
                    state_n    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            S_RESP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            a_idx  <= '0;
            a_we   <= 1'b0;
            iack_q <= 1'b0;
            ierr_q <= 1'b0;
            idat_q <= 32'h0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                a_idx <= req_off[ADDR_WIDTH+1:2];
                a_we  <= bus.iwe_i;
            end
            iack_q <= enter_resp && !resp_err;
            ierr_q <= enter_resp && resp_err;
            idat_q <= (enter_resp && !resp_err && !cur_we) ? mem[cur_idx] : 32'h0;
        end
    end

`ifdef IMEM_WRITE_EN
    logic [3:0]  a_sel, cur_sel;
    logic [31:0] a_dat, cur_dat;
    logic        unused_bits;

    assign cur_sel     = (state == S_IDLE) ? bus.isel_i : a_sel;
    assign cur_dat     = (state == S_IDLE) ? bus.idat_i : a_dat;
    assign unused_bits = ^req_off[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_sel <= 4'h0;
            a_dat <= 32'h0;
        end else if (accept) begin
            a_sel <= bus.isel_i;
            a_dat <= bus.idat_i;
        end
    end

    // Byte lanes are committed on the edge that starts the ack pulse.
    always_ff @(posedge clk) begin
        if (rst && enter_resp && !resp_err && cur_we) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_sel[b]) begin
                    mem[cur_idx][8*b +: 8] <= cur_dat[8*b +: 8];
                end
            end
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{req_off[1:0], bus.isel_i, bus.idat_i};
`endif

    assign bus.idat_o = idat_q;
    assign bus.iack_o = iack_q;
    assign bus.ierr_o = ierr_q;
endmodule

// File: tb/tb_imem_wb_responder.sv
// tb/tb_imem_wb_responder.sv - self-checking bench for imem_wb_responder (LATENCY 1 and 3 instances)
module tb_imem_wb_responder;
    localparam logic [31:0] TB_BASE  = 32'h0000_0000;
    localparam int          TB_DEPTH = 1024;
`ifdef IMEM_WRITE_EN
    localparam bit TB_WREN = 1'b1;
`else
    localparam bit TB_WREN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    imem_wb_responder_if b1();
    imem_wb_responder_if b3();

    imem_wb_responder #(.ADDR_WIDTH(10), .BASE_ADDR(TB_BASE), .LATENCY(1), .MEM_FILE(""))
        u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    imem_wb_responder #(.ADDR_WIDTH(10), .BASE_ADDR(TB_BASE), .LATENCY(3), .MEM_FILE(""))
        u3 (.clk(clk), .rst(rst), .bus(b3.slave));

    typedef struct {
        int          which;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdat;
        int          abort_j;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_dat;
        int          exp_k;
    } vec_t;

    vec_t        vecs [$];
    logic [31:0] ref_mem [2][TB_DEPTH];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'h0000_0513;
            1:       return 32'h0040_0593;
            2:       return 32'h1234_5678;
            3:       return 32'h0010_0093;
            default: return 32'h1357_0000 ^ (32'(i) * 32'h0001_0101);
        endcase
    endfunction

    function automatic vec_t mk(input int which, input logic [31:0] addr, input logic we,
                                input logic [3:0] sel, input logic [31:0] wdat, input int abort_j,
                                input logic ea, input logic ee, input logic [31:0] ed, input int ek);
        vec_t v;
        v.which = which; v.addr = addr; v.we = we; v.sel = sel; v.wdat = wdat;
        v.abort_j = abort_j; v.exp_ack = ea; v.exp_err = ee; v.exp_dat = ed; v.exp_k = ek;
        return v;
    endfunction

    function automatic logic [33:0] get_out(input int which);
        if (which == 1) return {b1.iack_o, b1.ierr_o, b1.idat_o};
        return {b3.iack_o, b3.ierr_o, b3.idat_o};
    endfunction

    task automatic set_bus(input int which, input logic cyc, input logic stb, input logic we,
                           input logic [31:0] addr, input logic [31:0] dat, input logic [3:0] sel);
        if (which == 1) begin
            b1.icyc_i = cyc; b1.istb_i = stb; b1.iwe_i = we;
            b1.iaddr_i = addr; b1.idat_i = dat; b1.isel_i = sel;
        end else begin
            b3.icyc_i = cyc; b3.istb_i = stb; b3.iwe_i = we;
            b3.iaddr_i = addr; b3.idat_i = dat; b3.isel_i = sel;
        end
    endtask

    task automatic chk(input string nm, input logic [33:0] got, input logic [33:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got ack=%0b err=%0b dat=%h, expected ack=%0b err=%0b dat=%h",
                     nm, got[33], got[32], got[31:0], exp[33], exp[32], exp[31:0]);
        end
    endtask

    // Drives one request and compares every cycle from the accepting edge
    // through the mandatory idle cycle after the expected termination.
    task automatic run_txn(input int which, input logic [31:0] addr, input logic we,
                           input logic [3:0] sel, input logic [31:0] wdat, input int abort_j,
                           input logic exp_ack, input logic exp_err, input logic [31:0] exp_dat,
                           input int exp_k, input string nm);
        logic [33:0] exp;
        int          wi;
        int          idx;
        wi = (which == 1) ? 0 : 1;
        set_bus(which, 1'b1, 1'b1, we, addr, wdat, sel);
        for (int k = 0; k <= exp_k + 1; k++) begin
            @(negedge clk);
            exp = (k == exp_k) ? {exp_ack, exp_err, exp_dat} : 34'h0;
            chk($sformatf("%s_k%0d", nm, k), get_out(which), exp);
            if (k == exp_k || (abort_j > 0 && k + 1 == abort_j))
                set_bus(which, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        end
        if (exp_ack && we) begin
            idx = int'((addr - TB_BASE) >> 2);
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[wi][idx][8*b +: 8] = wdat[8*b +: 8];
        end
    endtask

    function automatic bit is_bad(input logic [31:0] a, input logic we);
        logic [31:0] off;
        off = a - TB_BASE;
        return (a[1:0] != 2'b00) || (a < TB_BASE) || ((off >> 2) >= 32'(TB_DEPTH)) || (we && !TB_WREN);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic        we, bad, ab;
        int          lat, wi, r, aj;

        for (int i = 0; i < TB_DEPTH; i++) begin
            u1.mem[i] = init_word(i);
            u3.mem[i] = init_word(i);
            ref_mem[0][i] = init_word(i);
            ref_mem[1][i] = init_word(i);
        end

        // Reset held with an active request on both buses: nothing may answer.
        set_bus(1, 1'b1, 1'b1, 1'b0, 32'hC, 32'h0, 4'hF);
        set_bus(3, 1'b1, 1'b1, 1'b0, 32'hC, 32'h0, 4'hF);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("reset_u1", get_out(1), 34'h0);
            chk("reset_u3", get_out(3), 34'h0);
        end
        set_bus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_bus(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst = 1'b1;
        @(negedge clk);

        vecs.push_back(mk(1, 32'hC,     1'b0, 4'hF, 32'h0, 0, 1'b1, 1'b0, 32'h0010_0093, 1));
        vecs.push_back(mk(1, 32'h0,     1'b0, 4'hF, 32'h0, 0, 1'b1, 1'b0, init_word(0), 1));
        vecs.push_back(mk(1, 32'h4,     1'b0, 4'hF, 32'h0, 0, 1'b1, 1'b0, init_word(1), 1));
        vecs.push_back(mk(1, 32'h8,     1'b0, 4'hF, 32'h0, 0, 1'b1, 1'b0, init_word(2), 1));
        vecs.push_back(mk(1, 32'hC,     1'b0, 4'hF, 32'h0, 0, 1'b1, 1'b0, init_word(3), 1));
        vecs.push_back(mk(1, 32'h6,     1'b0, 4'hF, 32'h0, 0, 1'b0, 1'b1, 32'h0, 0));
        vecs.push_back(mk(1, 32'h1000,  1'b0, 4'hF, 32'h0, 0, 1'b0, 1'b1, 32'h0, 0));
        vecs.push_back(mk(3, 32'h0,     1'b0, 4'hF, 32'h0, 1, 1'b0, 1'b0, 32'h0, 3));
        vecs.push_back(mk(3, 32'h0,     1'b0, 4'hF, 32'h0, 0, 1'b1, 1'b0, init_word(0), 3));
        vecs.push_back(mk(3, 32'h6,     1'b0, 4'hF, 32'h0, 0, 1'b0, 1'b1, 32'h0, 0));
`ifdef IMEM_WRITE_EN
        vecs.push_back(mk(1, 32'h8,     1'b1, 4'b0011, 32'hDEAD_BEEF, 0, 1'b1, 1'b0, 32'h0, 1));
        vecs.push_back(mk(1, 32'h8,     1'b0, 4'hF, 32'h0, 0, 1'b1, 1'b0, 32'h1234_BEEF, 1));
`else
        vecs.push_back(mk(1, 32'h8,     1'b1, 4'b0011, 32'hDEAD_BEEF, 0, 1'b0, 1'b1, 32'h0, 0));
        vecs.push_back(mk(1, 32'h8,     1'b0, 4'hF, 32'h0, 0, 1'b1, 1'b0, 32'h1234_5678, 1));
`endif
        vecs.push_back(mk(1, 32'hFFC,   1'b0, 4'hF, 32'h0, 0, 1'b1, 1'b0, init_word(1023), 1));
        vecs.push_back(mk(3, 32'hFFC,   1'b0, 4'hF, 32'h0, 0, 1'b1, 1'b0, init_word(1023), 3));

        foreach (vecs[i])
            run_txn(vecs[i].which, vecs[i].addr, vecs[i].we, vecs[i].sel, vecs[i].wdat,
                    vecs[i].abort_j, vecs[i].exp_ack, vecs[i].exp_err, vecs[i].exp_dat,
                    vecs[i].exp_k, $sformatf("vec%0d", i));

        // istb_i left high after the ack: one idle cycle, then a second request.
        set_bus(1, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("stb_held_k%0d", k), get_out(1),
                (k == 1 || k == 4) ? {2'b10, init_word(1)} : 34'h0);
            if (k == 4) set_bus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        end

        // Address and write enable changing during WAIT must be ignored.
        set_bus(3, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("wait_latch_k%0d", k), get_out(3),
                (k == 3) ? {2'b10, init_word(1)} : 34'h0);
            if (k == 0) set_bus(3, 1'b1, 1'b1, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'hF);
            if (k == 3) set_bus(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        end

        // Reset during an ack (u1) and during WAIT (u3): outputs clear at once, no later response.
        set_bus(1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
        set_bus(3, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
        @(negedge clk);
        @(negedge clk);
        chk("midrst_ack_before", get_out(1), {2'b10, init_word(0)});
        rst = 1'b0;
        #1;
        chk("midrst_u1_cleared", get_out(1), 34'h0);
        set_bus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_bus(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("midrst_quiet_u1_c%0d", c), get_out(1), 34'h0);
            chk($sformatf("midrst_quiet_u3_c%0d", c), get_out(3), 34'h0);
        end

        // Randomised traffic against a transaction-level model.
        for (int w = 0; w < 2; w++) begin
            wi  = w;
            lat = (w == 0) ? 1 : 3;
            for (int t = 0; t < 80; t++) begin
                r = $urandom_range(0, 9);
                case (r)
                    6:       a = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
                    7:       a = 32'h1000 + (32'($urandom_range(0, 4095)) << 2);
                    8:       a = 32'hFFFF_FFFC;
                    9:       a = 32'hFFC;
                    default: a = 32'($urandom_range(0, 1023)) << 2;
                endcase
                we  = ($urandom_range(0, 3) == 0);
                bad = is_bad(a, we);
                ab  = (!bad && lat > 1 && $urandom_range(0, 4) == 0);
                aj  = ab ? $urandom_range(1, lat) : 0;
                begin
                    logic [3:0]  s;
                    logic [31:0] d;
                    logic [31:0] ed;
                    s  = 4'($urandom);
                    d  = $urandom;
                    ed = (bad || ab || we) ? 32'h0 : ref_mem[wi][int'((a - TB_BASE) >> 2)];
                    run_txn((w == 0) ? 1 : 3, a, we, s, d, aj, !bad && !ab, bad, ed,
                            bad ? 0 : lat, $sformatf("rnd_l%0d_t%0d", lat, t));
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
